fsk_jietiao: RTL

- Non-coherent 2FSK demodulator directly downstream of the tiaozhi modulator.
- Consumes the 1-bit square-wave FSK stream (shuchu) and the bit-rate clock (clk1).
- Counts FSK rising edges in each bit period and decides the bit by threshold compare.
- Emits one recovered bit per period with a one-cycle valid strobe, plus an out-of-range error flag.

---
 rtl/fsk_jietiao_pkg.sv | 9 +
 rtl/fsk_jietiao_if.sv | 15 +
 rtl/fsk_jietiao_edge_sync.sv | 56 +++++
 rtl/fsk_jietiao.sv | 105 ++++++++++
 4 files changed

// File: rtl/fsk_jietiao_pkg.sv
// Shared types and default constants for the fsk_jietiao 2FSK demodulator.
package fsk_pkg;
   typedef enum logic [1:0] {IDLE, ALIGN, COUNT} state_e;

   localparam int CNT_W_DEF     = 8;
   localparam int THRESH_DEF    = 4;
   localparam int MIN_EDGES_DEF = 1;
   localparam int MAX_EDGES_DEF = 12;
endpackage

// File: rtl/fsk_jietiao_if.sv
// Demodulator stream bundle: FSK/bit-clock inputs and decoded-bit outputs.
interface fsk_jietiao_if import fsk_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
   logic             enable;
   logic             fsk_in;
   logic             bit_clk;
   logic             data_out;
   logic             data_valid;
   logic             err;
   logic [CNT_W-1:0] edge_cnt_dbg;

   modport master (output enable, fsk_in, bit_clk,
                   input  data_out, data_valid, err, edge_cnt_dbg);
   modport slave  (input  enable, fsk_in, bit_clk,
                   output data_out, data_valid, err, edge_cnt_dbg);
endinterface

// File: rtl/fsk_jietiao_edge_sync.sv
// 2-FF synchronizer plus registered rising-edge pulse, with optional
// 3-sample majority filter (FILTER) or one matching delay flop (EXTRA_DLY).
module edge_sync #(
   parameter bit FILTER    = 1'b0,
   parameter bit EXTRA_DLY = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);
   logic s1_q, s2_q, prev_q, rise_q;
   logic cond;
   logic rise_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= d;
         s2_q   <= s1_q;
         prev_q <= cond;
         rise_q <= rise_d;
      end
   end

   generate
      if (FILTER) begin : g_filt
         // Window is {hist_q[1], hist_q[0], s2_q}; a single-cycle pulse never wins the vote.
         logic [1:0] hist_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hist_q <= 2'b00;
            else        hist_q <= {hist_q[0], s2_q};
         end
         assign cond = (s2_q & hist_q[0]) | (s2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
      end else if (EXTRA_DLY) begin : g_dly
         logic dly_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dly_q <= 1'b0;
            else        dly_q <= s2_q;
         end
         assign cond = dly_q;
      end else begin : g_pass
         assign cond = s2_q;
      end
   endgenerate

   always_comb begin
      rise_d = cond & ~prev_q;
   end

   assign rise = rise_q;
endmodule

// File: rtl/fsk_jietiao.sv
// Non-coherent 2FSK demodulator: counts FSK rising edges per bit period.
// Define FSK_DEGLITCH_EN to add a majority filter on fsk_in (+1 cycle latency).
module fsk_jietiao import fsk_pkg::*; #(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int THRESH      = THRESH_DEF,
   parameter int MIN_EDGES   = MIN_EDGES_DEF,
   parameter int MAX_EDGES   = MAX_EDGES_DEF,
   parameter bit HIGH_IS_ONE = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   fsk_jietiao_if.slave  bus
);
`ifdef FSK_DEGLITCH_EN
   localparam bit DEGLITCH = 1'b1;
`else
   localparam bit DEGLITCH = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic fsk_rise, bit_rise;

   edge_sync #(.FILTER(DEGLITCH), .EXTRA_DLY(1'b0)) u_fsk_sync (
      .clk(clk), .rst_n(rst_n), .d(bus.fsk_in), .rise(fsk_rise)
   );

   // bit_clk gets the same extra delay as the filter so periods stay aligned.
   edge_sync #(.FILTER(1'b0), .EXTRA_DLY(DEGLITCH)) u_bit_sync (
      .clk(clk), .rst_n(rst_n), .d(bus.bit_clk), .rise(bit_rise)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] dbg_q, dbg_d;
   logic             data_out_q, data_out_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] closing;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dbg_q      <= '0;
         data_out_q <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dbg_q      <= dbg_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dbg_d      = dbg_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      err_d      = err_q;
      // An edge coinciding with the boundary belongs to the closing period.
      closing    = (fsk_rise && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

      if (!bus.enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = ALIGN;
            end
            ALIGN: begin
               cnt_d = '0;
               if (bit_rise) state_d = COUNT;
            end
            COUNT: begin
               if (bit_rise) begin
                  dbg_d      = closing;
                  data_out_d = ((int'(closing) >= THRESH) == HIGH_IS_ONE);
                  err_d      = (int'(closing) < MIN_EDGES) || (int'(closing) > MAX_EDGES);
                  valid_d    = 1'b1;
                  cnt_d      = '0;
               end else begin
                  cnt_d = closing;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign bus.data_out     = data_out_q;
   assign bus.data_valid   = valid_q;
   assign bus.err          = err_q;
   assign bus.edge_cnt_dbg = dbg_q;
endmodule
